// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and the
// per-entry state record.
package bp_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    // Tag and target widths depend on the instance parameters, so those fields
    // are stored in separately sized arrays next to this record.
    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } bp_entry_t;

    function automatic logic bp_ctr_taken(input logic [1:0] ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating direction counter: next state from current state and the
// resolved outcome.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != BP_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup, resolve-time
// update and mispredict detection. Define BP_STATS_EN to add statistic counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lookup_valid,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            resolve_valid,
    input  logic [XLEN-1:0] resolve_pc,
    input  logic [XLEN-1:0] resolve_target,
    input  logic            resolve_taken,
    input  logic            resolve_pred_taken,
    input  logic [XLEN-1:0] resolve_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
        $error("branch_predictor: ENTRIES must be a power of two >= 2");
    end

    bp_entry_t        entry_q  [ENTRIES];
    bp_entry_t        entry_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [XLEN-1:0]  target_d [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] rs_idx;
    logic [TAG_W-1:0] rs_tag;
    logic             rs_hit;
    logic [1:0]       ctr_upd;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign rs_idx = resolve_pc[IDX_W+1:2];
    assign rs_tag = resolve_pc[XLEN-1:IDX_W+2];

    always_comb begin
        pred_hit    = entry_q[lk_idx].valid && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && bp_ctr_taken(entry_q[lk_idx].ctr);
        pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + XLEN'(4);
    end

    assign mispredict  = resolve_valid &&
                         ((resolve_taken != resolve_pred_taken) ||
                          (resolve_taken && (resolve_target != resolve_pred_target)));
    assign redirect_pc = resolve_taken ? resolve_target : resolve_pc + XLEN'(4);

    assign rs_hit = entry_q[rs_idx].valid && (tag_q[rs_idx] == rs_tag);

    bp_sat_counter u_sat_counter (
        .ctr      (entry_q[rs_idx].ctr),
        .taken    (resolve_taken),
        .ctr_next (ctr_upd)
    );

    always_comb begin
        entry_d  = entry_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (resolve_valid) begin
            if (rs_hit) begin
                entry_d[rs_idx].ctr = ctr_upd;
                if (resolve_taken) target_d[rs_idx] = resolve_target;
            end else if (resolve_taken) begin
                // Taken miss replaces whatever lives at this index.
                entry_d[rs_idx].valid = 1'b1;
                entry_d[rs_idx].ctr   = BP_WT;
                tag_d[rs_idx]         = rs_tag;
                target_d[rs_idx]      = resolve_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i].valid <= 1'b0;
                entry_q[i].ctr   <= BP_WNT;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_lookups_q;
    logic [31:0] stat_lookups_d;
    logic [31:0] stat_mispredicts_q;
    logic [31:0] stat_mispredicts_d;

    always_comb begin
        stat_lookups_d     = stat_lookups_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (lookup_valid && stat_lookups_q != 32'hFFFF_FFFF)
            stat_lookups_d = stat_lookups_q + 32'd1;
        if (mispredict && stat_mispredicts_q != 32'hFFFF_FFFF)
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups_q     <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups     = stat_lookups_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    logic unused_lookup_valid;
    assign unused_lookup_valid = lookup_valid;
`endif

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/target width.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning number of BTB entries (power of two, >=2; elaboration error otherwise).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port lookup_valid  input  1  fetch presents a PC this cycle.
REQ-006 SHALL have port lookup_pc  input  XLEN  fetch-stage PC.
REQ-007 SHALL have port pred_hit  output  1  valid entry with matching tag.
REQ-008 SHALL have port pred_taken  output  1  predicted-taken.
REQ-009 SHALL have port pred_target  output  XLEN  next fetch PC.
REQ-010 SHALL have port resolve_valid  input  1  decode has resolved a branch/jump.
REQ-011 SHALL have ports resolve_pc, resolve_target  input  XLEN  branch PC and computed target.
REQ-012 SHALL have port resolve_taken  input  1  actual outcome.
REQ-013 SHALL have ports resolve_pred_taken (1), resolve_pred_target (XLEN)  input  prediction carried down the pipe.
REQ-014 SHALL have port mispredict  output  1  flush request to fetch/decode.
REQ-015 SHALL have port redirect_pc  output  XLEN  correct next PC on mispredict.

Function
REQ-016 SHALL index with lookup_pc[IDX_W+1:2], IDX_W=log2(ENTRIES); tag = lookup_pc[XLEN-1:IDX_W+2].
REQ-017 SHALL store per entry: valid, tag, target, 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-018 SHALL produce lookup outputs combinationally (zero latency): pred_hit = valid & tag match; pred_taken = pred_hit & ctr[1].
REQ-019 SHALL drive pred_target = stored target when pred_taken, else lookup_pc+4 (modulo 2^XLEN).
REQ-020 SHALL drive mispredict = resolve_valid & (resolve_taken != resolve_pred_taken | (resolve_taken & resolve_target != resolve_pred_target)), combinationally.
REQ-021 SHALL drive redirect_pc = resolve_target when resolve_taken, else resolve_pc+4.
REQ-022 SHALL, on resolve_valid with tag hit, update the counter saturating (11 stays 11 on taken, 00 stays 00 on not-taken) and overwrite target when taken, at the next rising edge.
REQ-023 SHALL, on resolve_valid with miss and resolve_taken=1, allocate (overwrite) the indexed entry: valid=1, new tag, target, counter=10.
REQ-024 SHALL NOT allocate on a not-taken miss.
REQ-025 SHALL return pre-update contents when lookup and update address the same index in one cycle (no bypass).
REQ-026 SHALL ignore lookup_valid for table contents; it only affects statistics.

Reset
REQ-027 SHALL clear all valid bits and set all counters to 01 while rst=1, asynchronously; tags/targets need no reset.
REQ-028 SHALL, during and immediately after reset, yield pred_hit=0, pred_taken=0, pred_target=lookup_pc+4; mispredict/redirect_pc remain combinational functions of inputs.
REQ-029 SHALL abandon any update coincident with reset assertion.

Configuration
REQ-030 SHALL, with BP_STATS_EN defined, add outputs stat_lookups and stat_mispredicts (32 bits each, reset 0): increment per cycle of lookup_valid and of mispredict, saturating at 0xFFFFFFFF.
REQ-031 SHALL, without BP_STATS_EN, omit both ports and counters entirely.

Structure
REQ-032 SHALL place counter-state localparams (SNT/WNT/WT/ST) and the entry struct typedef in shared package bp_pkg.
REQ-033 SHALL implement the counter update as sub-module bp_sat_counter (2-bit state + outcome in, next state out).

Verification
REQ-034 Reset, lookup 0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-035 Resolve 0x100 taken target 0x200, pred 0/0x104 -> mispredict=1, redirect 0x200; next cycle lookup 0x100 -> hit, taken, target 0x200.
REQ-036 Three not-taken resolves of 0x100 after REQ-035 -> counter 10->01->00->00; lookup shows hit=1, taken=0, target 0x104.
REQ-037 ENTRIES=16: allocate 0x100 then taken 0x140 (same index, new tag) -> 0x100 misses, 0x140 hits.
REQ-038 Same-cycle lookup and allocate of 0x300 -> pred_hit=0 that cycle, 1 next cycle.
REQ-039 With BP_STATS_EN: 10 lookup cycles, 2 mispredicts -> stat_lookups=10, stat_mispredicts=2; rst mid-run -> both 0.
